// File: rtl/cpu_fetch.sv
// cpu_fetch: instruction-fetch stage owning the PC, the imem read port and the IF/ID register.
module cpu_fetch #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] imem_addr,
    output logic        imem_rd_en,
    input  logic [15:0] imem_data,
    input  logic        imem_ready,
    output logic [15:0] instrD,
    output logic [15:0] pcPlus2D,
    output logic        validD,
    output logic        halted,
    output logic [15:0] fetch_count
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t      state, state_nx;
    logic [15:0] pc, pc_nx, instr_nx, pc2_nx, count_nx;
    logic        valid_nx;
    logic [15:0] target;
    logic [15:0] pc_plus2;

    assign target     = {branch_target[15:1], 1'b0};
    assign pc_plus2   = pc + 16'd2;
    assign imem_addr  = pc;
    assign imem_rd_en = (state == RUN) & ~stall;
    assign halted     = (state == HALTED);

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = instrD;
        pc2_nx   = pcPlus2D;
        valid_nx = validD;
        count_nx = fetch_count;
        if (!stall) begin
            // Any non-stalled cycle that does not latch a fetch inserts a bubble.
            instr_nx = NOP_INSTR;
            pc2_nx   = 16'h0000;
            valid_nx = 1'b0;
            if (branch_taken) begin
                pc_nx    = target;
                state_nx = RUN;
            end else if (state == RUN && imem_ready) begin
                instr_nx = imem_data;
                pc2_nx   = pc_plus2;
                valid_nx = 1'b1;
                count_nx = fetch_count + 16'd1;
                state_nx = (imem_data[15:12] == HALT_OPCODE) ? HALTED : RUN;
                pc_nx    = (imem_data[15:12] == HALT_OPCODE) ? pc : pc_plus2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            instrD      <= NOP_INSTR;
            pcPlus2D    <= 16'h0000;
            validD      <= 1'b0;
            fetch_count <= 16'h0000;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            instrD      <= instr_nx;
            pcPlus2D    <= pc2_nx;
            validD      <= valid_nx;
            fetch_count <= count_nx;
        end
    end
endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: directed and randomized checks of cpu_fetch against a cycle-level behavioural model.
module tb_cpu_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_ready = 1'b0;
    logic [15:0] instrD;
    logic [15:0] pcPlus2D;
    logic        validD;
    logic        halted;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc, m_instr, m_pc2, m_count;
    logic        m_valid, m_halted;

    cpu_fetch dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
        .imem_data(imem_data), .imem_ready(imem_ready), .instrD(instrD),
        .pcPlus2D(pcPlus2D), .validD(validD), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000;
        m_count = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    endtask

    task automatic check_regs();
        chk("imem_addr", imem_addr, m_pc);
        chk("instrD", instrD, m_instr);
        chk("pcPlus2D", pcPlus2D, m_pc2);
        chk("validD", {15'b0, validD}, {15'b0, m_valid});
        chk("halted", {15'b0, halted}, {15'b0, m_halted});
        chk("fetch_count", fetch_count, m_count);
    endtask

    task automatic bubble();
        m_instr = 16'h0000; m_pc2 = 16'h0000; m_valid = 1'b0;
    endtask

    // One clock: drive inputs, check the combinational read port, advance the model, check registers.
    task automatic cyc(input logic s, input logic b, input logic [15:0] t,
                       input logic r, input logic [15:0] d);
        stall = s; branch_taken = b; branch_target = t; imem_ready = r; imem_data = d;
        #1;
        chk("imem_rd_en", {15'b0, imem_rd_en}, {15'b0, (!m_halted && !s)});
        chk("imem_addr_pre", imem_addr, m_pc);
        if (!s) begin
            if (b) begin
                m_pc = t & 16'hFFFE;
                m_halted = 1'b0;
                bubble();
            end else if (m_halted || !r) begin
                bubble();
            end else begin
                m_instr = d; m_pc2 = m_pc + 16'd2; m_valid = 1'b1; m_count = m_count + 16'd1;
                if (d[15:12] == 4'hF) m_halted = 1'b1;
                else m_pc = m_pc + 16'd2;
            end
        end
        @(posedge clk); #1;
        check_regs();
    endtask

    initial begin
        logic [15:0] d;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        chk("reset_instr", instrD, 16'h0000);
        rst_n = 1'b1;

        cyc(0, 0, 0, 1, 16'h1123);
        cyc(0, 0, 0, 1, 16'h2456);
        chk("tp1_instr", instrD, 16'h2456);
        cyc(0, 0, 0, 1, 16'h3789);
        chk("tp1_pc2", pcPlus2D, 16'h0006);
        chk("tp1_addr", imem_addr, 16'h0006);
        chk("tp1_count", fetch_count, 16'd3);

        cyc(0, 1, 16'h0010, 1, 16'h1111);
        cyc(0, 0, 0, 1, 16'hF000);
        chk("hlt_instr", instrD, 16'hF000);
        chk("hlt_pc2", pcPlus2D, 16'h0012);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 16'h1234);
        chk("hlt_addr", imem_addr, 16'h0010);
        chk("hlt_halted", {15'b0, halted}, 16'd1);

        cyc(0, 1, 16'h0041, 1, 16'h1234);
        chk("resume_addr", imem_addr, 16'h0040);
        chk("resume_halted", {15'b0, halted}, 16'd0);
        cyc(0, 0, 0, 1, 16'h2222);
        chk("resume_pc2", pcPlus2D, 16'h0042);

        cyc(0, 1, 16'h0008, 1, 16'h0);
        cyc(0, 0, 0, 1, 16'h3333);
        cyc(1, 1, 16'h0200, 1, 16'h4444);
        chk("stall_addr", imem_addr, 16'h000A);
        chk("stall_instr", instrD, 16'h3333);
        cyc(0, 1, 16'h0100, 1, 16'h4444);
        chk("redir_addr", imem_addr, 16'h0100);

        cyc(0, 1, 16'h0020, 1, 16'h0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 16'h5555);
        chk("wait_addr", imem_addr, 16'h0020);
        cyc(0, 0, 0, 1, 16'h6666);
        chk("wait_pc2", pcPlus2D, 16'h0022);

        cyc(0, 1, 16'hFFFE, 1, 16'h0);
        cyc(0, 0, 0, 1, 16'h7777);
        chk("wrap_pc2", pcPlus2D, 16'h0000);
        chk("wrap_addr", imem_addr, 16'h0000);

        for (int i = 0; i < 400; i++) begin
            d = 16'($urandom);
            if ($urandom_range(0, 7) != 0) d[15:12] = 4'($urandom_range(0, 14));
            cyc($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, 16'($urandom),
                $urandom_range(0, 3) != 0, d);
        end

        stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1; imem_data = 16'h1357;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        chk("async_rd_en", {15'b0, imem_rd_en}, 16'd1);
        @(posedge clk); #1;
        check_regs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
